imem_loader: RTL and testbench

- Writer side of the instruction-memory interface: receives a program as a byte stream and writes 32-bit little-endian instruction words into instruction memory.
- Sits between a host byte link (UART/testbench) and the imem write port.
- Holds the RV32I core in reset until the image has loaded and its checksum has been verified.

---
 rtl/imem_loader.sv | 150 +++++++++++++++
 tb/tb_imem_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian words, writes them to imem,
// verifies an XOR checksum and releases the core hold on success.
module imem_loader #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {StIdle, StHdr, StData, StWrite, StCsum, StDone, StErr} state_e;

   localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [32:0]           Capacity = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);

   state_e                state_q, state_d;
   logic                  byte_ready_d, imem_we_d, cpu_hold_d, done_d, error_d;
   logic [ADDR_WIDTH-1:0] imem_addr_d;
   logic [31:0]           imem_wdata_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
   logic [ADDR_WIDTH:0]   nwords_q, nwords_d;
   logic [31:0]           csum_q, csum_d;
   logic [23:0]           shreg_q, shreg_d;
   logic                  fire, last;
   logic [31:0]           word_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         byte_ready <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= BaseAddr;
         imem_wdata <= '0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
         byte_cnt_q <= '0;
         word_cnt_q <= '0;
         nwords_q   <= '0;
         csum_q     <= '0;
         shreg_q    <= '0;
      end else begin
         state_q    <= state_d;
         byte_ready <= byte_ready_d;
         imem_we    <= imem_we_d;
         imem_addr  <= imem_addr_d;
         imem_wdata <= imem_wdata_d;
         cpu_hold   <= cpu_hold_d;
         done       <= done_d;
         error      <= error_d;
         byte_cnt_q <= byte_cnt_d;
         word_cnt_q <= word_cnt_d;
         nwords_q   <= nwords_d;
         csum_q     <= csum_d;
         shreg_q    <= shreg_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr;
      imem_wdata_d = imem_wdata;
      cpu_hold_d   = cpu_hold;
      done_d       = done;
      error_d      = error;
      byte_cnt_d   = byte_cnt_q;
      word_cnt_d   = word_cnt_q;
      nwords_d     = nwords_q;
      csum_d       = csum_q;
      shreg_d      = shreg_q;

      fire      = byte_valid && byte_ready;
      last      = fire && (byte_cnt_q == 2'd3);
      // Newest byte enters at the top, so byte 0 ends up in bits [7:0].
      word_full = {byte_data, shreg_q};
      if (fire) begin
         shreg_d    = word_full[31:8];
         byte_cnt_d = byte_cnt_q + 2'd1;
      end

      unique case (state_q)
         StIdle, StDone, StErr: begin
            if (start) begin
               state_d     = StHdr;
               done_d      = 1'b0;
               error_d     = 1'b0;
               byte_cnt_d  = '0;
               word_cnt_d  = '0;
               csum_d      = '0;
               cpu_hold_d  = 1'b1;
               imem_addr_d = BaseAddr;
            end
         end
         StHdr: begin
            if (last) begin
               nwords_d = word_full[ADDR_WIDTH:0];
               if ({1'b0, word_full} > Capacity) begin
                  state_d = StErr;
                  error_d = 1'b1;
               end else if (word_full == 32'd0) begin
                  state_d = StCsum;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (last) begin
               state_d      = StWrite;
               imem_we_d    = 1'b1;
               imem_wdata_d = word_full;
            end
         end
         StWrite: begin
            csum_d      = csum_q ^ imem_wdata;
            word_cnt_d  = word_cnt_q + 1'b1;
            imem_addr_d = imem_addr + 1'b1;
            state_d     = (word_cnt_d == nwords_q) ? StCsum : StData;
         end
         StCsum: begin
            if (last) begin
               if (word_full == csum_q) begin
                  state_d    = StDone;
                  done_d     = 1'b1;
                  cpu_hold_d = 1'b0;
               end else begin
                  state_d = StErr;
                  error_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      byte_ready_d = (state_d == StHdr) || (state_d == StData) || (state_d == StCsum);
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; a default-size instance and a
// 16-word instance share the stimulus, selected by sel.
module tb_imem_loader;

   logic       clk = 1'b0;
   logic       rst_n, start, byte_valid, sel;
   logic [7:0] byte_data;

   logic        br10, we10, hold10, done10, err10;
   logic [9:0]  addr10;
   logic [31:0] wd10;
   logic        br4, we4, hold4, done4, err4;
   logic [3:0]  addr4;
   logic [31:0] wd4;

   logic        br_m, we_m, hold_m, done_m, err_m;
   logic [9:0]  addr_m;
   logic [31:0] wd_m;

   always #5 clk = ~clk;

   imem_loader #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dut10 (
      .clk(clk), .rst_n(rst_n), .start(start && !sel), .byte_valid(byte_valid && !sel),
      .byte_data(byte_data), .byte_ready(br10), .imem_we(we10), .imem_addr(addr10),
      .imem_wdata(wd10), .cpu_hold(hold10), .done(done10), .error(err10)
   );

   imem_loader #(.ADDR_WIDTH(4), .BASE_ADDR(0)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start && sel), .byte_valid(byte_valid && sel),
      .byte_data(byte_data), .byte_ready(br4), .imem_we(we4), .imem_addr(addr4),
      .imem_wdata(wd4), .cpu_hold(hold4), .done(done4), .error(err4)
   );

   assign br_m   = sel ? br4 : br10;
   assign we_m   = sel ? we4 : we10;
   assign hold_m = sel ? hold4 : hold10;
   assign done_m = sel ? done4 : done10;
   assign err_m  = sel ? err4 : err10;
   assign addr_m = sel ? {6'd0, addr4} : addr10;
   assign wd_m   = sel ? wd4 : wd10;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  stream[$];
   logic [31:0] wr_data[$];
   int          wr_addr[$];

   always @(negedge clk) begin
      if (we_m) begin
         wr_data.push_back(wd_m);
         wr_addr.push_back(int'(addr_m));
      end
   end

   task automatic push_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) stream.push_back(w[8*k +: 8]);
   endtask

   // Drives the current stream; returns how many bytes the DUT took within budget cycles.
   task automatic send_bytes(input bit bp, input int budget, output int accepted);
      int idx = 0;
      int cyc = 0;
      bit xfer;
      while (idx < stream.size() && cyc < budget) begin
         @(negedge clk);
         byte_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         byte_data  = stream[idx];
         xfer       = byte_valid && br_m;
         @(posedge clk);
         if (xfer) idx++;
         cyc++;
      end
      @(negedge clk);
      byte_valid = 1'b0;
      accepted   = idx;
   endtask

   task automatic load(input bit bp, input int budget, output int accepted, output bit timed_out);
      int c = 0;
      wr_data.delete();
      wr_addr.delete();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      send_bytes(bp, budget, accepted);
      timed_out = 1'b1;
      while (c < 40) begin
         if (done_m || err_m) begin
            timed_out = 1'b0;
            break;
         end
         @(negedge clk);
         c++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #13;
      n_checks++;
      if ({br_m, we_m, hold_m, done_m, err_m} !== 5'b00100) begin
         n_fail++;
         $display("FAIL reset_in: {rdy,we,hold,done,err}=%b expected 00100",
                  {br_m, we_m, hold_m, done_m, err_m});
      end
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({br_m, we_m, hold_m, done_m, err_m} !== 5'b00100 || addr_m !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_out: {rdy,we,hold,done,err}=%b addr=%0d expected 00100 addr=0",
                  {br_m, we_m, hold_m, done_m, err_m}, addr_m);
      end
   endtask

   task automatic test_nominal(input bit bad_csum);
      logic [31:0] w[2] = '{32'h0050_0093, 32'h00A0_0113};
      int acc;
      bit to;
      stream.delete();
      push_word(32'd2);
      push_word(w[0]);
      push_word(w[1]);
      push_word(bad_csum ? 32'd0 : (w[0] ^ w[1]));
      load(1'b0, 100, acc, to);
      n_checks++;
      if (to || acc !== 16) begin
         n_fail++;
         $display("FAIL nominal_bytes(bad=%0b): accepted=%0d timeout=%0b expected 16, 0",
                  bad_csum, acc, to);
      end
      n_checks++;
      if (wr_data.size() !== 2) begin
         n_fail++;
         $display("FAIL nominal_nwrites(bad=%0b): got %0d expected 2", bad_csum, wr_data.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (wr_data[i] !== w[i] || wr_addr[i] !== i) begin
               n_fail++;
               $display("FAIL nominal_write%0d: %h@%0d expected %h@%0d", i, wr_data[i],
                        wr_addr[i], w[i], i);
            end
         end
      end
      n_checks++;
      if ({done_m, err_m, hold_m} !== (bad_csum ? 3'b011 : 3'b100)) begin
         n_fail++;
         $display("FAIL nominal_end(bad=%0b): {done,err,hold}=%b expected %b", bad_csum,
                  {done_m, err_m, hold_m}, bad_csum ? 3'b011 : 3'b100);
      end
      n_checks++;
      if (addr_m !== 10'd2 || br_m !== 1'b0) begin
         n_fail++;
         $display("FAIL nominal_addr: addr=%0d rdy=%b expected 2, 0", addr_m, br_m);
      end
   endtask

   task automatic test_oversize;
      int acc;
      bit to;
      sel = 1'b1;
      stream.delete();
      push_word(32'd17);
      push_word(32'h1234_5678);
      load(1'b0, 30, acc, to);
      n_checks++;
      if (to || acc !== 4) begin
         n_fail++;
         $display("FAIL oversize_bytes: accepted=%0d timeout=%0b expected 4, 0", acc, to);
      end
      n_checks++;
      if ({done_m, err_m, hold_m} !== 3'b011 || wr_data.size() !== 0) begin
         n_fail++;
         $display("FAIL oversize_end: {done,err,hold}=%b writes=%0d expected 011, 0",
                  {done_m, err_m, hold_m}, wr_data.size());
      end
      sel = 1'b0;
   endtask

   task automatic test_zero_backpressure;
      int acc;
      bit to;
      stream.delete();
      push_word(32'd0);
      push_word(32'd0);
      load(1'b1, 200, acc, to);
      n_checks++;
      if (to || acc !== 8) begin
         n_fail++;
         $display("FAIL zero_bytes: accepted=%0d timeout=%0b expected 8, 0", acc, to);
      end
      n_checks++;
      if ({done_m, err_m, hold_m} !== 3'b100 || wr_data.size() !== 0 || br_m !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_end: {done,err,hold}=%b writes=%0d rdy=%b expected 100, 0, 0",
                  {done_m, err_m, hold_m}, wr_data.size(), br_m);
      end
   endtask

   task automatic test_reset_midload;
      int acc;
      bit to;
      stream.delete();
      push_word(32'd2);
      push_word(32'h0BAD_F00D);
      stream.push_back(8'h55);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      send_bytes(1'b0, 40, acc);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({br_m, we_m, hold_m, done_m, err_m} !== 5'b00100 || addr_m !== 10'd0) begin
         n_fail++;
         $display("FAIL midreset_async: {rdy,we,hold,done,err}=%b addr=%0d expected 00100, 0",
                  {br_m, we_m, hold_m, done_m, err_m}, addr_m);
      end
      @(negedge clk) rst_n = 1'b1;
      stream.delete();
      push_word(32'd1);
      push_word(32'hDEAD_BEEF);
      push_word(32'hDEAD_BEEF);
      load(1'b0, 100, acc, to);
      n_checks++;
      if (to || wr_data.size() !== 1) begin
         n_fail++;
         $display("FAIL restart_nwrites: got %0d timeout=%0b expected 1, 0", wr_data.size(), to);
      end else begin
         n_checks++;
         if (wr_data[0] !== 32'hDEAD_BEEF || wr_addr[0] !== 0) begin
            n_fail++;
            $display("FAIL restart_write: %h@%0d expected deadbeef@0", wr_data[0], wr_addr[0]);
         end
      end
      n_checks++;
      if ({done_m, err_m, hold_m} !== 3'b100) begin
         n_fail++;
         $display("FAIL restart_end: {done,err,hold}=%b expected 100", {done_m, err_m, hold_m});
      end
   endtask

   task automatic test_random;
      for (int it = 0; it < 8; it++) begin
         int          n;
         bit          bad, bp, to;
         int          acc;
         logic [31:0] w[$];
         logic [31:0] x;
         n   = $urandom_range(1, 7);
         bad = ($urandom_range(0, 3) == 0);
         bp  = 1'($urandom_range(0, 1));
         x   = '0;
         stream.delete();
         push_word(32'(n));
         for (int i = 0; i < n; i++) begin
            w.push_back($urandom());
            x ^= w[i];
            push_word(w[i]);
         end
         push_word(bad ? (x ^ (32'd1 << $urandom_range(0, 31))) : x);
         load(bp, 400, acc, to);
         n_checks++;
         if (to || acc !== 8 + 4 * n) begin
            n_fail++;
            $display("FAIL rand%0d_bytes: accepted=%0d timeout=%0b expected %0d, 0", it, acc, to,
                     8 + 4 * n);
         end
         n_checks++;
         if (wr_data.size() !== n) begin
            n_fail++;
            $display("FAIL rand%0d_nwrites: got %0d expected %0d", it, wr_data.size(), n);
         end else begin
            for (int i = 0; i < n; i++) begin
               n_checks++;
               if (wr_data[i] !== w[i] || wr_addr[i] !== i) begin
                  n_fail++;
                  $display("FAIL rand%0d_write%0d: %h@%0d expected %h@%0d", it, i, wr_data[i],
                           wr_addr[i], w[i], i);
               end
            end
         end
         n_checks++;
         if ({done_m, err_m, hold_m} !== (bad ? 3'b011 : 3'b100)) begin
            n_fail++;
            $display("FAIL rand%0d_end: {done,err,hold}=%b expected %b", it,
                     {done_m, err_m, hold_m}, bad ? 3'b011 : 3'b100);
         end
      end
   endtask

   initial begin
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      sel        = 1'b0;
      test_reset();
      test_nominal(1'b0);
      test_nominal(1'b1);
      test_oversize();
      test_zero_backpressure();
      test_reset_midload();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
